// File: rtl/serial_hadd_pkg.sv
// Shared types and sizing helpers for the bit-serial half-adder sequencer.
package serial_hadd_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} seq_state_t;

  localparam int REQ_N = 2;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_hadd_seq_hadd_cell.sv
// Single half-adder cell shared by every serial step of the sequencer.
module hadd_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_hadd_seq.sv
// Two-requester arbiter feeding a bit-serial operand+cin sequencer built on one half-adder.
// Optional SERIAL_HADD_EARLY_EXIT_EN: finish as soon as the running carry is zero.
module serial_hadd_seq
  import serial_hadd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REQ_N-1:0] req,
  input  logic [WIDTH-1:0] op0,
  input  logic [WIDTH-1:0] op1,
  input  logic [REQ_N-1:0] cin,
  output logic [REQ_N-1:0] gnt,
  output logic [REQ_N-1:0] ack,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  seq_state_t       state, state_nxt;
  logic [WIDTH-1:0] sh, sh_nxt;
  logic             carry, carry_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             g, g_nxt;
  logic             rr_last, rr_nxt;
  logic             win;
  logic             fin;
  logic             hs, hc;
  logic [REQ_N-1:0] g_oh;

  hadd_cell u_hadd (
    .a (sh[0]),
    .b (carry),
    .s (hs),
    .c (hc)
  );

  // On contention the requester that did not win last time goes next.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) win = ~rr_last;
    else if (req[1])  win = 1'b1;
  end

`ifdef SERIAL_HADD_EARLY_EXIT_EN
  // Rotating by the unprocessed span puts the finished low bits back at LSB.
  logic [CW:0]        amt;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  assign amt = (CW+1)'(WIDTH) - {1'b0, cnt};
  assign dbl = {sh, sh} >> amt;
  assign rot = dbl[WIDTH-1:0];
`endif

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    g_nxt     = g;
    rr_nxt    = rr_last;
    fin       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          g_nxt     = win;
          rr_nxt    = win;
          sh_nxt    = win ? op1 : op0;
          carry_nxt = cin[win];
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
`ifdef SERIAL_HADD_EARLY_EXIT_EN
        if (!carry) begin
          sh_nxt    = rot;
          state_nxt = DONE;
          fin       = 1'b1;
        end else
`endif
        begin
          sh_nxt    = {hs, sh[WIDTH-1:1]};
          carry_nxt = hc;
          cnt_nxt   = cnt + 1'b1;
          if (cnt == LAST) begin
            state_nxt = DONE;
            fin       = 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sh      <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      g       <= 1'b0;
      rr_last <= 1'b1;
      result  <= '0;
      cout    <= 1'b0;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      carry   <= carry_nxt;
      cnt     <= cnt_nxt;
      g       <= g_nxt;
      rr_last <= rr_nxt;
      if (fin) begin
        result <= sh_nxt;
        cout   <= carry_nxt;
      end
    end
  end

  assign g_oh = g ? 2'b10 : 2'b01;
  assign busy = (state != IDLE);
  assign gnt  = busy ? g_oh : '0;
  assign ack  = (state == DONE) ? g_oh : '0;

endmodule

// File: tb/tb_serial_hadd_seq.sv
// Directed + randomized bench for serial_hadd_seq with an arithmetic reference model.
module tb_serial_hadd_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req;
  logic [W-1:0] op0, op1;
  logic [1:0]   cin;
  logic [1:0]   gnt, ack;
  logic         busy;
  logic [W-1:0] result;
  logic         cout;

  int vecs = 0;
  int errs = 0;
  logic rr_model;

  serial_hadd_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op0    (op0),
    .op1    (op1),
    .cin    (cin),
    .gnt    (gnt),
    .ack    (ack),
    .busy   (busy),
    .result (result),
    .cout   (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int t_ones(input logic [W-1:0] v);
    int t = 0;
    while (t < W && v[t]) t++;
    return t;
  endfunction

  // Cycles from the sampling edge until the ack cycle is visible.
  function automatic int exp_lat(input logic [W-1:0] op, input logic c);
`ifdef SERIAL_HADD_EARLY_EXIT_EN
    int run;
    run = c ? t_ones(op) + 2 : 1;
    if (run > W) run = W;
    return run + 1;
`else
    return W + 1;
`endif
  endfunction

  // Waits for requester w to be served (inputs already driven), checks, drops its req.
  task automatic serve(input int w, input string tag);
    int n = 0;
    bit got = 0;
    logic [W-1:0] op;
    logic         c;
    logic [W:0]   sum;
    op  = (w == 1) ? op1 : op0;
    c   = cin[w];
    sum = {1'b0, op} + {{W{1'b0}}, c};
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_gnt_run"}, {30'd0, gnt}, (w == 1) ? 32'd2 : 32'd1);
        check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
      end
      if (ack != 2'b00) got = 1;
    end
    check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_ack"}, {30'd0, ack}, (w == 1) ? 32'd2 : 32'd1);
    check({tag, "_latency"}, n, exp_lat(op, c));
    check({tag, "_result"}, {16'd0, result}, {16'd0, sum[W-1:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, sum[W]});
    rr_model = (w == 1);
    req[w] = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, {30'd0, ack}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; op0 = '0; op1 = '0; cin = 2'b00;
    rr_model = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Both held from reset: req0 first, then req1, and again in that order.
    op0 = 16'h1234; op1 = 16'hFFFF; cin = 2'b11; req = 2'b11;
    serve(0, "t3a");
    serve(1, "t3b");
    op0 = 16'h0003; op1 = 16'h7FFF; cin = 2'b11; req = 2'b11;
    serve(0, "t3c");
    serve(1, "t3d");

    op0 = 16'h1234; cin = 2'b01; req = 2'b01;
    serve(0, "t1");
    op1 = 16'hFFFF; cin = 2'b10; req = 2'b10;
    serve(1, "t2");
    op0 = 16'hA5A5; cin = 2'b00; req = 2'b01;
    serve(0, "t4");
    op0 = 16'h0000; cin = 2'b00; req = 2'b01;
    serve(0, "t6z");

    // Reset during RUN: no ack, outputs cleared, then normal service.
    op0 = 16'hFFFF; cin = 2'b01; req = 2'b01;
    repeat (5) @(negedge clk);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    reset = 1'b1; req = 2'b00;
    @(negedge clk);
    reset = 1'b0;
    rr_model = 1'b1;
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_gnt", {30'd0, gnt}, 32'd0);
    check("t5_ack", {30'd0, ack}, 32'd0);
    check("t5_result", {16'd0, result}, 32'd0);
    check("t5_cout", {31'd0, cout}, 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("t5_no_ack", {30'd0, ack}, 32'd0);
    end
    op1 = 16'h00FF; cin = 2'b10; req = 2'b10;
    serve(1, "t5_after");

    // Randomized traffic with arbitration tracked by the model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0] pat;
      int first;
      pat = 2'($urandom_range(1, 3));
      op0 = 16'($urandom);
      op1 = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
      if (i % 7 == 3) op0 = 16'($urandom) | 16'h00FF;
      cin = 2'($urandom);
      req = pat;
      if (pat == 2'b11) begin
        first = rr_model ? 0 : 1;
        serve(first, "rnd_a");
        serve(1 - first, "rnd_b");
      end else begin
        serve(pat[1] ? 1 : 0, "rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
